// File: rtl/reg_op_ctrl.sv
// Command-side controller for the 4-bit register-op unit: load seed, apply op N times, return result.
// Optional one-entry command buffer enabled by defining REG_OP_CMD_BUF_EN.
module reg_op_ctrl #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_data,
   input  logic [CNT_W-1:0] cmd_cnt,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_data,
   output logic [1:0]       op_s,
   output logic             op_load,
   output logic [3:0]       op_reg_in,
   input  logic [3:0]       op_reg_out,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [3:0]       data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

`ifdef REG_OP_CMD_BUF_EN
   logic             bvld_q, bvld_d;
   logic [1:0]       bop_q, bop_d;
   logic [3:0]       bdata_q, bdata_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;

   // Gated by reset so every output reads 0 while reset is held.
   assign cmd_ready = reset & ~bvld_q;
`else
   assign cmd_ready = reset & (state_q == IDLE);
`endif
   assign accept = cmd_valid & cmd_ready;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
`ifdef REG_OP_CMD_BUF_EN
      bvld_d  = bvld_q;
      bop_d   = bop_q;
      bdata_d = bdata_q;
      bcnt_d  = bcnt_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef REG_OP_CMD_BUF_EN
            if (bvld_q) begin
               op_d = bop_q; data_d = bdata_q; cnt_d = bcnt_q;
               bvld_d = 1'b0; state_d = LOAD;
            end else
`endif
            if (accept) begin
               op_d = cmd_op; data_d = cmd_data; cnt_d = cmd_cnt;
               state_d = LOAD;
            end
         end
         LOAD: state_d = (cnt_q == '0) ? RESP : EXEC;
         EXEC: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
`ifdef REG_OP_CMD_BUF_EN
               // Drain the buffer straight into LOAD to skip the IDLE bubble.
               if (bvld_q) begin
                  op_d = bop_q; data_d = bdata_q; cnt_d = bcnt_q;
                  bvld_d = 1'b0; state_d = LOAD;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef REG_OP_CMD_BUF_EN
      // Accepts while busy land in the buffer; applied after the drain so a refill wins.
      if (accept && state_q != IDLE) begin
         bvld_d = 1'b1; bop_d = cmd_op; bdata_d = cmd_data; bcnt_d = cmd_cnt;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef REG_OP_CMD_BUF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bvld_q  <= 1'b0;
         bop_q   <= '0;
         bdata_q <= '0;
         bcnt_q  <= '0;
      end else begin
         bvld_q  <= bvld_d;
         bop_q   <= bop_d;
         bdata_q <= bdata_d;
         bcnt_q  <= bcnt_d;
      end
   end
`endif

   always_comb begin
      op_s      = 2'b00;
      op_load   = 1'b0;
      op_reg_in = 4'h0;
      rsp_valid = 1'b0;
      rsp_data  = 4'h0;
      busy      = (state_q != IDLE);
      case (state_q)
         LOAD: begin
            op_load   = 1'b1;
            op_reg_in = data_q;
         end
         EXEC: begin
            op_load   = 1'b1;
            op_s      = op_q;
            op_reg_in = op_reg_out;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_data  = op_reg_out;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reg_op_ctrl.sv
// Randomized self-checking bench for reg_op_ctrl, with a behavioural register-op unit attached.
// Buffer-mode checks are compiled in when REG_OP_CMD_BUF_EN is defined.
module tb_reg_op_ctrl;
   logic       clk = 0;
   logic       reset;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data, cmd_cnt;
   logic       rsp_valid, rsp_ready;
   logic [3:0] rsp_data;
   logic [1:0] op_s;
   logic       op_load;
   logic [3:0] op_reg_in, op_reg_out;
   logic       busy;
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   reg_op_ctrl #(.CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .op_s(op_s), .op_load(op_load), .op_reg_in(op_reg_in), .op_reg_out(op_reg_out),
      .busy(busy)
   );

   function automatic logic [3:0] apply_op(input logic [1:0] op, input logic [3:0] v);
      case (op)
         2'b00:   return v;
         2'b01:   return ~v;
         2'b10:   return v >> 1;
         default: return (v << 1) & 4'hF;
      endcase
   endfunction

   // External register-op unit: mux selected by op_s feeding a load register.
   logic [3:0] unit_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) unit_q <= '0;
      else if (op_load) unit_q <= apply_op(op_s, op_reg_in);
   assign op_reg_out = unit_q;

   function automatic logic [3:0] ref_res(input logic [1:0] op, input logic [3:0] d, input int n);
      logic [3:0] v = d;
      for (int i = 0; i < n; i++) v = apply_op(op, v);
      return v;
   endfunction

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [3:0] d, input logic [3:0] c);
      int n = 0;
      cmd_op = op; cmd_data = d; cmd_cnt = c; cmd_valid = 1;
      while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) chk("cmd_ready_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [3:0] d, input logic [3:0] c,
                          input int hold);
      int k, loads;
      logic [3:0] exp;
      exp = ref_res(op, d, int'(c));
      send_cmd(op, d, c);
      k = 1; loads = 0;
      while (!rsp_valid && k < 100) begin
         if (op_load) loads++;
         @(posedge clk); #1; k++;
      end
      chk("latency", k, int'(c) + 2);
      chk("load_cycles", loads, int'(c) + 1);
      chk("rsp_data", rsp_data, exp);
      chk("busy_resp", busy, 1);
      for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
      if (hold > 0) begin
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_data, exp);
         chk("hold_load", op_load, 0);
`ifndef REG_OP_CMD_BUF_EN
         chk("hold_cmd_ready", cmd_ready, 0);
`endif
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      chk("post_busy", busy, 0);
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      reset = 0; cmd_valid = 0; cmd_op = 0; cmd_data = 0; cmd_cnt = 0; rsp_ready = 0;
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1;
      @(posedge clk); #1;
      chk("init_cmd_ready", cmd_ready, 1);
      chk("init_busy", busy, 0);

      // reset asserted mid-EXEC clears outputs without waiting for a clock edge
      send_cmd(2'b01, 4'b0110, 4'd10);
      repeat (3) @(posedge clk);
      #3;
      chk("pre_rst_load", op_load, 1);
      reset = 0; #1;
      chk("arst_busy", busy, 0);
      chk("arst_op_load", op_load, 0);
      chk("arst_op_s", op_s, 0);
      chk("arst_op_reg_in", op_reg_in, 0);
      chk("arst_rsp_valid", rsp_valid, 0);
      chk("arst_rsp_data", rsp_data, 0);
      chk("arst_cmd_ready", cmd_ready, 0);
      @(negedge clk); reset = 1;
      @(posedge clk); #1;
      chk("rel_cmd_ready", cmd_ready, 1);
      chk("rel_busy", busy, 0);

      run_cmd(2'b11, 4'b0011, 4'd2, 0);   // -> 1100
      run_cmd(2'b01, 4'b1010, 4'd3, 0);   // -> 0101
      run_cmd(2'b10, 4'b1000, 4'd0, 5);   // load only, held response
      run_cmd(2'b10, 4'b1111, 4'd15, 1);  // max count -> 0000

`ifdef REG_OP_CMD_BUF_EN
      // A runs, B buffered during A's EXEC, C stalls until the buffer drains
      send_cmd(2'b11, 4'b0001, 4'd1);
      @(posedge clk); #1;
      cmd_op = 2'b01; cmd_data = 4'b0000; cmd_cnt = 4'd0; cmd_valid = 1;
      chk("buf_a_exec_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 0;
      chk("buf_a_valid", rsp_valid, 1);
      chk("buf_a_data", rsp_data, ref_res(2'b11, 4'b0001, 1));
      chk("buf_full_stall", cmd_ready, 0);
      cmd_op = 2'b00; cmd_data = 4'b0110; cmd_cnt = 4'd0; cmd_valid = 1;
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      chk("buf_b_load", op_load, 1);
      chk("buf_b_reg_in", op_reg_in, 4'b0000);
      chk("buf_b_busy", busy, 1);
      chk("buf_drained_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 0;
      chk("buf_b_valid", rsp_valid, 1);
      chk("buf_b_data", rsp_data, 4'b0000);
      chk("buf_c_stall", cmd_ready, 0);
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      chk("buf_c_load", op_load, 1);
      chk("buf_c_reg_in", op_reg_in, 4'b0110);
      @(posedge clk); #1;
      chk("buf_c_data", rsp_data, 4'b0110);
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      chk("buf_end_busy", busy, 0);
`endif

      for (int t = 0; t < 40; t++) begin
         logic [1:0] op;
         logic [3:0] d, c;
         op = 2'($urandom_range(0, 3));
         d  = 4'($urandom_range(0, 15));
         c  = 4'($urandom_range(0, 15));
         run_cmd(op, d, c, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
